// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - opcodes, instruction field positions and FSM states for proc_core
package proc_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LI   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BEQZ = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hE;
  localparam logic [3:0] OP_OUT  = 4'hF;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RA_HI  = 11;
  localparam int RA_LO  = 9;
  localparam int RB_HI  = 8;
  localparam int RB_LO  = 6;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALTED
  } state_t;

endpackage

// File: rtl/proc_regfile.sv
// rtl/proc_regfile.sv - 8-entry register file, two async read ports, one sync write port
module proc_regfile #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        raddr_a,
  input  logic [2:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [8];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/proc_core.sv
// rtl/proc_core.sv - multicycle 16-bit-instruction processor, FETCH/DECODE/EXEC/WB
// JMP/BEQZ are built only when PROC_BRANCH_EN is defined.
module proc_core
  import proc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic [15:0]       instruction,
  output logic [PC_W-1:0]   imem_addr,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              halted,
  output logic              illegal
);

  state_t            state, state_next;
  logic [PC_W-1:0]   pc, pc_next;
  logic [15:0]       ir;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic              op_legal, op_writes, reg_we;

  logic [3:0] opcode;
  logic [2:0] ra, rb;
  logic [7:0] imm;

  assign opcode = ir[OPC_HI:OPC_LO];
  assign ra     = ir[RA_HI:RA_LO];
  assign rb     = ir[RB_HI:RB_LO];
  assign imm    = ir[IMM_HI:IMM_LO];

  proc_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_a (ra),
    .raddr_b (rb),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .we      (reg_we),
    .waddr   (ra),
    .wdata   (alu_q)
  );

  always_comb begin
    alu_d = '0;
    case (opcode)
      OP_LI:   alu_d = DATA_W'(imm);
      OP_ADD:  alu_d = rdata_a + rdata_b;
      OP_SUB:  alu_d = rdata_a - rdata_b;
      OP_AND:  alu_d = rdata_a & rdata_b;
      OP_OR:   alu_d = rdata_a | rdata_b;
      OP_XOR:  alu_d = rdata_a ^ rdata_b;
      OP_OUT:  alu_d = rdata_a;
      default: alu_d = '0;
    endcase
  end

  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_NOP, OP_LI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_HALT, OP_OUT: op_legal = 1'b1;
`ifdef PROC_BRANCH_EN
      OP_JMP, OP_BEQZ: op_legal = 1'b1;
`endif
      default:         op_legal = 1'b0;
    endcase
  end

  assign op_writes = (opcode == OP_LI) || (opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND) || (opcode == OP_OR) || (opcode == OP_XOR);
  assign reg_we    = step && (state == WB) && op_writes;

`ifdef PROC_BRANCH_EN
  // Branch decision is captured in EXEC alongside the ALU result.
  logic taken_q, taken_d;
  assign taken_d = (opcode == OP_JMP) || ((opcode == OP_BEQZ) && (rdata_a == '0));
  assign pc_next = taken_q ? imm[PC_W-1:0] : pc + PC_W'(1);
`else
  assign pc_next = pc + PC_W'(1);
`endif

  always_comb begin
    state_next = state;
    if (step) begin
      case (state)
        FETCH:   state_next = DECODE;
        DECODE:  state_next = EXEC;
        EXEC:    state_next = WB;
        WB:      state_next = (opcode == OP_HALT) ? HALTED : FETCH;
        HALTED:  state_next = HALTED;
        default: state_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= FETCH;
      pc           <= '0;
      ir           <= '0;
      alu_q        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      illegal      <= 1'b0;
`ifdef PROC_BRANCH_EN
      taken_q      <= 1'b0;
`endif
    end else begin
      state        <= state_next;
      result_valid <= 1'b0;
      if (step) begin
        case (state)
          DECODE: ir <= instruction;
          EXEC: begin
            alu_q <= alu_d;
`ifdef PROC_BRANCH_EN
            taken_q <= taken_d;
`endif
          end
          WB: begin
            pc <= pc_next;
            if (opcode == OP_OUT) begin
              result       <= alu_q;
              result_valid <= 1'b1;
            end
            if (!op_legal) illegal <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_addr = pc;
  assign halted    = (state == HALTED);

endmodule

// File: tb/tb_proc_core.sv
// tb/tb_proc_core.sv - directed-program bench for proc_core (DATA_W 16 and 8 instances)
module tb_proc_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step = 1'b0;
  logic [15:0] rom [8];
  logic [15:0] instr16, instr8;

  logic [2:0]  addr16, addr8;
  logic [15:0] result16;
  logic [7:0]  result8;
  logic        rv16, rv8, halted16, halted8, illegal16, illegal8;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc, pulses, last_pulse;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    instr16 <= rom[addr16];
    instr8  <= rom[addr8];
  end

  proc_core #(.DATA_W(16), .PC_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .step(step), .instruction(instr16),
    .imem_addr(addr16), .result(result16), .result_valid(rv16),
    .halted(halted16), .illegal(illegal16)
  );

  proc_core #(.DATA_W(8), .PC_W(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .step(step), .instruction(instr8),
    .imem_addr(addr8), .result(result8), .result_valid(rv8),
    .halted(halted8), .illegal(illegal8)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [15:0] w);
    for (int i = 0; i < 8; i++) rom[i] = w;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0; pulses = 0; last_pulse = 0;
  endtask

  // step is high on every period-th cycle; pulses are tagged with the edge count
  task automatic run(input int n, input int period);
    for (int k = 0; k < n; k++) begin
      step = ((cyc % period) == 0);
      @(posedge clk);
      #1;
      cyc++;
      if (rv16) begin
        pulses++;
        last_pulse = cyc;
      end
    end
    step = 1'b0;
  endtask

  task automatic load_prog_a();
    fill(16'hE000);
    rom[0] = 16'h1205; // LI r1,5
    rom[1] = 16'h1407; // LI r2,7
    rom[2] = 16'h2280; // ADD r1,r2
    rom[3] = 16'hF200; // OUT r1
  endtask

  initial begin
    fill(16'h0000);

    do_reset();
    run(3, 1000000);
    check_eq("rst_addr", 32'(addr16), 32'h0);
    check_eq("rst_result", 32'(result16), 32'h0);
    check_eq("rst_valid", 32'(rv16), 32'h0);
    check_eq("rst_halted", 32'(halted16), 32'h0);
    check_eq("rst_illegal", 32'(illegal16), 32'h0);

    load_prog_a();
    do_reset();
    run(19, 1);
    check_eq("a_halted_early", 32'(halted16), 32'h0);
    run(1, 1);
    check_eq("a_result", 32'(result16), 32'h000C);
    check_eq("a_pulses", 32'(pulses), 32'd1);
    check_eq("a_pulse_edge", 32'(last_pulse), 32'd16);
    check_eq("a_halted", 32'(halted16), 32'h1);
    check_eq("a_halt_addr", 32'(addr16), 32'h5);
    run(20, 1);
    check_eq("a_halt_hold", 32'(halted16), 32'h1);
    check_eq("a_halt_addr_frozen", 32'(addr16), 32'h5);
    check_eq("a_halt_no_pulse", 32'(pulses), 32'd1);

    do_reset();
    run(60, 3);
    check_eq("slow_result", 32'(result16), 32'h000C);
    check_eq("slow_pulses", 32'(pulses), 32'd1);
    check_eq("slow_pulse_edge", 32'(last_pulse), 32'd46);

    fill(16'hE000);
    rom[0] = 16'h1600; // LI r3,0
    rom[1] = 16'h1801; // LI r4,1
    rom[2] = 16'h3700; // SUB r3,r4
    rom[3] = 16'hF600; // OUT r3
    do_reset();
    run(20, 1);
    check_eq("sub_result16", 32'(result16), 32'hFFFF);
    check_eq("sub_result8", 32'(result8), 32'hFF);
    check_eq("sub_valid8_cleared", 32'(rv8), 32'h0);

    fill(16'h0000);
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      run(4, 1);
      check_eq($sformatf("nop_addr_%0d", i), 32'(addr16), 32'(i % 8));
    end

    fill(16'h0000);
    rom[5] = 16'h8002; // JMP 2
    do_reset();
    run(24, 1);
`ifdef PROC_BRANCH_EN
    check_eq("jmp_addr", 32'(addr16), 32'h2);
    check_eq("jmp_illegal", 32'(illegal16), 32'h0);
`else
    check_eq("jmp_addr", 32'(addr16), 32'h6);
    check_eq("jmp_illegal", 32'(illegal16), 32'h1);
`endif

    fill(16'h0000);
    rom[0] = 16'h1201; // LI r1,1
    rom[1] = 16'h9207; // BEQZ r1,7
    rom[2] = 16'h9406; // BEQZ r2,6
    do_reset();
    run(8, 1);
    check_eq("beqz_nz_addr", 32'(addr16), 32'h2);
    run(4, 1);
`ifdef PROC_BRANCH_EN
    check_eq("beqz_z_addr", 32'(addr16), 32'h6);
`else
    check_eq("beqz_z_addr", 32'(addr16), 32'h3);
`endif

    fill(16'h0000);
    rom[0] = 16'h1205; // LI r1,5
    rom[1] = 16'hA240; // undefined opcode on r1
    rom[2] = 16'hF200; // OUT r1
    do_reset();
    run(4, 1);
    check_eq("ill_before", 32'(illegal16), 32'h0);
    run(4, 1);
    check_eq("ill_set", 32'(illegal16), 32'h1);
    check_eq("ill_result_kept", 32'(result16), 32'h0);
    run(8, 1);
    check_eq("ill_sticky", 32'(illegal16), 32'h1);
    check_eq("ill_reg_kept", 32'(result16), 32'h5);
    check_eq("ill_pulses", 32'(pulses), 32'd1);

    load_prog_a();
    do_reset();
    run(10, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst_addr", 32'(addr16), 32'h0);
    check_eq("midrst_result", 32'(result16), 32'h0);
    check_eq("midrst_valid", 32'(rv16), 32'h0);
    check_eq("midrst_halted", 32'(halted16), 32'h0);
    check_eq("midrst_illegal", 32'(illegal16), 32'h0);
    rom[0] = 16'hF200; // OUT r1 must see the cleared register
    rst_n = 1'b1;
    cyc = 0; pulses = 0; last_pulse = 0;
    run(4, 1);
    check_eq("midrst_r1", 32'(result16), 32'h0);
    check_eq("midrst_pulses", 32'(pulses), 32'd1);
    check_eq("midrst_pulse_edge", 32'(last_pulse), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/proc_core.md
# proc_core

Parametrised multicycle successor to the 3-bit-address demonstration processor. It fetches 16-bit instructions from an external synchronous instruction ROM and executes them through a four-state FSM. The data width and PC width are parametrised, an ALU and conditional branching are added, and the free-running timer divider is replaced by an external `step` enable. It sits between the board-level instruction ROM and the display/LED driver that consumes `result`.

## Interface
- `DATA_W`, 16: register/ALU/result width; minimum 8.
- `PC_W`, 3: instruction address width; legal range 1..8.
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `step` in 1: advance enable; the FSM moves only on edges where `step`=1.
- `instruction` in 16: ROM data, valid one cycle after `imem_addr`.
- `imem_addr` out PC_W: program counter.
- `result` out DATA_W: last OUT value.
- `result_valid` out 1: one-cycle pulse per OUT.
- `halted` out 1: HALT executed.
- `illegal` out 1: sticky; undefined opcode seen.

## Operation
- Fields: opcode[15:12], rA[11:9], rB[8:6], imm[7:0]. There are 8 registers, all general purpose.
- 0x0 NOP.
- 0x1 LI: rA ← zext(imm).
- 0x2 ADD, 0x3 SUB, 0x4 AND, 0x5 OR, 0x6 XOR: rA ← rA op rB.
- 0x8 JMP: PC ← imm[PC_W-1:0].
- 0x9 BEQZ: if rA==0 then PC ← imm[PC_W-1:0], else PC+1.
- 0xE HALT.
- 0xF OUT: `result` ← rA, pulse `result_valid`.
- Other opcodes: executed as NOP and set `illegal`.
- Arithmetic is modulo 2^DATA_W; there are no flags. `imm` is truncated to PC_W for branch targets.
- The PC increments modulo 2^PC_W unless a branch is taken.
- FSM: FETCH → DECODE → EXEC → WB → FETCH. HALT enters HALTED, which is left only by reset.
  - FETCH: `imem_addr`=PC is presented.
  - DECODE: `instruction` is latched into the IR.
  - EXEC: operands are read combinationally and the ALU/branch result is registered.
  - WB: the register write, `result`/`result_valid` update and PC update all occur on the WB edge.
- `step`=0 freezes all state. `result_valid` is still cleared on the next edge.
- In HALTED, `step` is ignored and `halted`=1.
- Reset dominates `step` and any state. On reset: FSM=FETCH, PC=0, IR=0, all registers=0, `result`=0, `result_valid`=0, `halted`=0, `illegal`=0.
- There are no read/write hazards, because reads (EXEC) and writes (WB) never overlap within the multicycle sequence.

## Timing
- Each instruction takes 4 enabled cycles. With `step` held at 1, instruction n's WB edge is enabled edge 4(n+1) after reset release.
- ROM latency is exactly 1 cycle. `imem_addr` is stable from FETCH through DECODE.
- `result_valid` is high for exactly the one cycle after the WB edge of an OUT, whether or not `step` stays high.
- `imem_addr` updates on the WB edge. The value is the next PC, which is the branch target for a taken JMP/BEQZ.
- Reset asserted mid-instruction aborts the instruction with no register write. Execution restarts at FETCH, PC 0, on the first edge after release.

## Configuration
- `PROC_BRANCH_EN` defined: JMP and BEQZ are implemented as above.
- Undefined: opcodes 0x8/0x9 are illegal. They execute as NOP, set `illegal`, and the PC always increments. The branch-compare logic is absent.

## Structure
- `proc_pkg`: opcode localparams, FSM state enum (FETCH, DECODE, EXEC, WB, HALTED), and instruction field bit positions.
- Sub-module `proc_regfile` #(DATA_W): 8 entries, two combinational read ports, one synchronous write port, and synchronous clear on `rst_n`.
- The ALU stays inline as a case statement in `proc_core`.

## Test plan
- Program LI r1,5; LI r2,7; ADD r1,r2; OUT r1, with `step`=1 → `result`=0x000C, `result_valid` high for one cycle after enabled edge 16, and no other pulse.
- LI r3,0; LI r4,1; SUB r3,r4; OUT r3 → `result`=0xFFFF (DATA_W=16). Repeat with DATA_W=8 → 0xFF.
- 8 NOPs with PC_W=3 → `imem_addr` runs 0..7 then wraps to 0. A JMP 2 at address 5 → next `imem_addr`=2. BEQZ on a nonzero register → `imem_addr`=addr+1.
- Opcode 0xA → `illegal`=1 and stays 1, with registers and `result` unchanged. With `PROC_BRANCH_EN` undefined, 0x8 behaves the same way.
- `step` toggled 1-in-3 during the first program → same `result`=0x000C, taking 3× the cycles, with exactly one `result_valid` pulse.
- `rst_n` pulsed low during EXEC of ADD → no write occurs and all outputs read 0. HALT followed by `step`=1 for 20 cycles → `halted`=1 and `imem_addr` frozen.
